// File: rtl/obi_pkg.sv
// Shared OBI bus widths and the per-master address-phase bundle used to slice
// the flat master-side vectors of the round-robin mux.
package obi_pkg;

    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;

    // Field order matches the concatenation used when slicing the flat ports.
    typedef struct packed {
        logic [OBI_AW-1:0]  addr;
        logic               we;
        logic [OBI_BEW-1:0] be;
        logic [OBI_DW-1:0]  wdata;
    } obi_req_t;

endpackage

// File: rtl/obi_mux_rr_id_fifo.sv
// In-order FIFO of master indices for outstanding reads: circular buffer plus
// an occupancy counter, head presented combinationally for zero-latency routing.
module obi_mux_rr_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/obi_mux_rr_n_to_1.sv
// Round-robin N-to-1 OBI mux with address-phase lock and pipelined in-order reads.
// Define OBI_MUX_RR_ZERO_RDATA_EN to zero read data on masters without rvalid.
module obi_mux_rr_n_to_1
    import obi_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    output logic [NUM_MASTERS-1:0]        m_gnt_o,
    input  logic [OBI_AW*NUM_MASTERS-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [OBI_BEW*NUM_MASTERS-1:0] m_be_i,
    input  logic [OBI_DW*NUM_MASTERS-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]        m_rvalid_o,
    output logic [OBI_DW*NUM_MASTERS-1:0] m_rdata_o,
    output logic                          shr_req_o,
    input  logic                          shr_gnt_i,
    output logic [OBI_AW-1:0]             shr_addr_o,
    output logic                          shr_we_o,
    output logic [OBI_BEW-1:0]            shr_be_o,
    output logic [OBI_DW-1:0]             shr_wdata_o,
    input  logic                          shr_rvalid_i,
    input  logic [OBI_DW-1:0]             shr_rdata_i
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    obi_req_t         m_reqs [NUM_MASTERS];
    obi_req_t         sel_req;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] lock_idx_reg;
    logic             lock_reg;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [IDX_W-1:0] sel;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
        assign m_reqs[gi] = {m_addr_i[gi*OBI_AW +: OBI_AW], m_we_i[gi],
                             m_be_i[gi*OBI_BEW +: OBI_BEW], m_wdata_i[gi*OBI_DW +: OBI_DW]};
    end

    // Circular search starting at rr_ptr; first requester wins.
    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!arb_found && m_req_i[IDX_W'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(cand);
            end
        end
    end

    assign sel       = lock_reg ? lock_idx_reg : arb_idx;
    assign sel_req   = m_reqs[sel];
    assign shr_req_o = !rst_i && (lock_reg ? m_req_i[sel] : arb_found);

    assign shr_addr_o  = sel_req.addr;
    assign shr_we_o    = sel_req.we;
    assign shr_be_o    = sel_req.be;
    assign shr_wdata_o = sel_req.wdata;

    assign pop    = !rst_i && shr_rvalid_i && !fifo_empty;
    // A full ID FIFO stalls only reads, unless a response frees a slot this cycle.
    assign accept = shr_gnt_i && shr_req_o && !(fifo_full && !pop && !shr_we_o);

    always_comb begin
        m_gnt_o       = '0;
        m_gnt_o[sel]  = accept;
        m_rvalid_o    = '0;
        m_rvalid_o[fifo_head] = pop;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            if (shr_req_o && !shr_gnt_i) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= sel;
            end else if (shr_gnt_i) begin
                lock_reg <= 1'b0;
            end
            if (accept) begin
                rr_ptr_reg <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
            end
        end
    end

    obi_mux_rr_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (accept && !shr_we_o),
        .push_data (sel),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef OBI_MUX_RR_ZERO_RDATA_EN
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rdata
        assign m_rdata_o[gi*OBI_DW +: OBI_DW] = m_rvalid_o[gi] ? shr_rdata_i : '0;
    end
`else
    assign m_rdata_o = {NUM_MASTERS{shr_rdata_i}};
`endif

endmodule

// File: tb/tb_obi_mux_rr_n_to_1.sv
// Bench for obi_mux_rr_n_to_1: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_obi_mux_rr_n_to_1;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_gnt;
    logic [32*N-1:0] m_addr;
    logic [N-1:0]    m_we;
    logic [4*N-1:0]  m_be;
    logic [32*N-1:0] m_wdata;
    logic [N-1:0]    m_rvalid;
    logic [32*N-1:0] m_rdata;
    logic            shr_req;
    logic            shr_gnt;
    logic [31:0]     shr_addr;
    logic            shr_we;
    logic [3:0]      shr_be;
    logic [31:0]     shr_wdata;
    logic            shr_rvalid;
    logic [31:0]     shr_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obi_mux_rr_n_to_1 #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .shr_req_o(shr_req), .shr_gnt_i(shr_gnt), .shr_addr_o(shr_addr), .shr_we_o(shr_we),
        .shr_be_o(shr_be), .shr_wdata_o(shr_wdata), .shr_rvalid_i(shr_rvalid),
        .shr_rdata_i(shr_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: pointer, lock and the list of masters owed a read.
    int m_rr = 0;
    bit m_lock = 0;
    int m_lock_idx = 0;
    int q[$];

    always @(negedge clk) begin
        int sel;
        bit req, found, pop, full, acc;
        logic [N-1:0] e_gnt, e_rv;
        logic [31:0] e_rdata;
        if (rst) begin
            chk("rst_gnt", 32'(m_gnt), 0);
            chk("rst_rvalid", 32'(m_rvalid), 0);
            chk("rst_req", 32'(shr_req), 0);
            m_rr = 0;
            m_lock = 0;
            q.delete();
        end else begin
            found = 0;
            sel = 0;
            if (m_lock) begin
                sel = m_lock_idx;
                req = m_req[sel];
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!found && m_req[(m_rr + i) % N]) begin
                        found = 1;
                        sel = (m_rr + i) % N;
                    end
                end
                req = found;
            end
            pop  = shr_rvalid && (q.size() > 0);
            full = (q.size() == MAXO);
            acc  = shr_gnt && req && !(full && !pop && !m_we[sel]);
            e_gnt = '0;
            e_rv  = '0;
            if (acc) e_gnt[sel] = 1'b1;
            if (pop) e_rv[q[0]] = 1'b1;
            chk("model_req", 32'(shr_req), 32'(req));
            chk("model_gnt", 32'(m_gnt), 32'(e_gnt));
            chk("model_rvalid", 32'(m_rvalid), 32'(e_rv));
            chk("model_addr", shr_addr, m_addr[32*sel +: 32]);
            chk("model_we", 32'(shr_we), 32'(m_we[sel]));
            chk("model_be", 32'(shr_be), 32'(m_be[4*sel +: 4]));
            chk("model_wdata", shr_wdata, m_wdata[32*sel +: 32]);
            for (int k = 0; k < N; k++) begin
`ifdef OBI_MUX_RR_ZERO_RDATA_EN
                e_rdata = e_rv[k] ? shr_rdata : 32'h0;
`else
                e_rdata = shr_rdata;
`endif
                chk("model_rdata", m_rdata[32*k +: 32], e_rdata);
            end
            if (req && !shr_gnt) begin
                m_lock = 1;
                m_lock_idx = sel;
            end else if (shr_gnt) begin
                m_lock = 0;
            end
            if (pop) void'(q.pop_front());
            if (acc) begin
                m_rr = (sel + 1) % N;
                if (!m_we[sel]) q.push_back(sel);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] rot_exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        rst = 1'b1;
        m_req = '1;
        m_we = '1;
        shr_gnt = 1'b1;
        shr_rvalid = 1'b0;
        shr_rdata = '0;
        for (int k = 0; k < N; k++) begin
            m_addr[32*k +: 32]  = 32'hA000_0000 + 32'(k * 16);
            m_be[4*k +: 4]      = 4'(k + 1);
            m_wdata[32*k +: 32] = 32'hD000_0000 + 32'(k);
        end

        // Reset holds everything quiet even with requests and grant present.
        @(negedge clk);
        chk("reset_gnt", 32'(m_gnt), 0);
        chk("reset_req", 32'(shr_req), 0);
        next();
        rst = 1'b0;

        // Rotation: all masters writing, slave always granting.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("rotate", 32'(m_gnt), 32'(rot_exp[i]));
            $display("rotate cycle %0d gnt=%b", i, m_gnt);
            next();
        end

        // Lock: master 2 stalled 3 cycles, master 0 arrives meanwhile (rr_ptr=3).
        m_req = 4'b0100;
        shr_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock_addr", shr_addr, 32'hA000_0020);
            chk("lock_nogrant", 32'(m_gnt), 0);
            $display("lock cycle %0d addr=%h", i, shr_addr);
            next();
            m_req = 4'b0101;
        end
        shr_gnt = 1'b1;
        @(negedge clk);
        chk("lock_release", 32'(m_gnt), 32'b0100);
        next();
        m_req = 4'b0001;
        @(negedge clk);
        chk("after_lock", 32'(m_gnt), 32'b0001);
        $display("after lock gnt=%b", m_gnt);
        next();

        // Pipelined reads: master 1 then master 3, responses in order.
        m_we = '0;
        m_req = 4'b0010;
        @(negedge clk);
        chk("rd1_gnt", 32'(m_gnt), 32'b0010);
        next();
        m_req = 4'b1000;
        @(negedge clk);
        chk("rd3_gnt", 32'(m_gnt), 32'b1000);
        next();
        m_req = '0;
        @(negedge clk);
        next();
        shr_rvalid = 1'b1;
        shr_rdata = 32'h11;
        @(negedge clk);
        chk("resp_a_rv", 32'(m_rvalid), 32'b0010);
        chk("resp_a_data", m_rdata[32*1 +: 32], 32'h11);
        $display("resp A rvalid=%b data=%h", m_rvalid, m_rdata[32*1 +: 32]);
        next();
        shr_rdata = 32'h22;
        @(negedge clk);
        chk("resp_b_rv", 32'(m_rvalid), 32'b1000);
        chk("resp_b_data", m_rdata[32*3 +: 32], 32'h22);
        $display("resp B rvalid=%b data=%h", m_rvalid, m_rdata[32*3 +: 32]);
        next();
        shr_rvalid = 1'b0;

        // Fill the FIFO, then a third read stalls while a write passes.
        m_req = 4'b0010;
        @(negedge clk);
        next();
        m_req = 4'b1000;
        @(negedge clk);
        next();
        m_req = 4'b0100;
        @(negedge clk);
        chk("full_read_blocked", 32'(m_gnt), 0);
        $display("full read gnt=%b", m_gnt);
        next();
        m_req = 4'b0001;
        m_we = 4'b0001;
        @(negedge clk);
        chk("full_write_pass", 32'(m_gnt), 32'b0001);
        $display("full write gnt=%b", m_gnt);
        next();

        // Full FIFO: read accepted in the same cycle as a response pops.
        m_we = '0;
        m_req = 4'b0100;
        shr_rvalid = 1'b1;
        shr_rdata = 32'h33;
        @(negedge clk);
        chk("swap_rv", 32'(m_rvalid), 32'b0010);
        chk("swap_gnt", 32'(m_gnt), 32'b0100);
        $display("swap rvalid=%b gnt=%b", m_rvalid, m_gnt);
        next();
        m_req = '0;
        shr_rdata = 32'h44;
        @(negedge clk);
        chk("drain_3", 32'(m_rvalid), 32'b1000);
        next();
        shr_rdata = 32'h55;
        @(negedge clk);
        chk("drain_2", 32'(m_rvalid), 32'b0100);
        next();
        shr_rdata = 32'h66;
        @(negedge clk);
        chk("empty_drop", 32'(m_rvalid), 0);
        $display("empty rvalid=%b", m_rvalid);
        next();
        shr_rvalid = 1'b0;

        // Reset with a read outstanding; stale response must be ignored.
        m_req = 4'b0010;
        @(negedge clk);
        chk("pre_rst_rd", 32'(m_gnt), 32'b0010);
        next();
        m_req = '0;
        rst = 1'b1;
        @(negedge clk);
        next();
        next();
        rst = 1'b0;
        m_req = '1;
        m_we = '1;
        shr_rvalid = 1'b1;
        shr_rdata = 32'h77;
        @(negedge clk);
        chk("post_rst_rv", 32'(m_rvalid), 0);
        chk("post_rst_gnt", 32'(m_gnt), 32'b0001);
        $display("post reset rvalid=%b gnt=%b", m_rvalid, m_gnt);
        next();
        m_req = '0;
        shr_rvalid = 1'b0;
        @(negedge clk);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
